// File: rtl/pc_sequencer_pkg.sv
// Shared PC-unit constants and next-PC source encoding, so the control unit and
// memory map agree on the vectors, increment and alignment.
package pc_sequencer_pkg;

    localparam int unsigned          DEF_WIDTH        = 32;
    localparam int unsigned          DEF_INC          = 4;
    localparam int unsigned          DEF_ALIGN_BITS   = 2;
    localparam logic [31:0]          DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0]          DEF_EXC_VECTOR   = 32'h8000_0180;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BRANCH,
        SEL_JUMP,
        SEL_JR,
        SEL_FAULT,
        SEL_HOLD,
        SEL_EXC
    } pc_sel_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux and target adders; purely combinational, the registers
// live in pc_sequencer.
module pc_next_sel
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned       WIDTH      = DEF_WIDTH,
    parameter int unsigned       INC        = DEF_INC,
    parameter int unsigned       ALIGN_BITS = DEF_ALIGN_BITS,
    parameter logic [WIDTH-1:0]  EXC_VECTOR = WIDTH'(DEF_EXC_VECTOR)
) (
    input  logic [WIDTH-1:0]              pc,
    input  logic                          enable,
    input  logic                          branch_taken,
    input  logic [WIDTH-1:0]              branch_offset,
    input  logic                          jump,
    input  logic [WIDTH-4-ALIGN_BITS-1:0] jump_index,
    input  logic                          jr,
    input  logic [WIDTH-1:0]              jr_target,
    input  logic                          exception,
    output logic [WIDTH-1:0]              pc_next_seq,
    output logic [WIDTH-1:0]              pc_d,
    output logic                          hold,
    output logic                          epc_load,
    output logic                          mis_d
);

    pc_sel_e          sel;
    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] j_target;

    // Both sums wrap modulo 2^WIDTH by truncation.
    assign pc_next_seq = pc + WIDTH'(INC);
    assign br_target   = pc_next_seq + (branch_offset << ALIGN_BITS);
    assign j_target    = {pc_next_seq[WIDTH-1 -: 4], jump_index, {ALIGN_BITS{1'b0}}};

    always_comb begin
        sel = SEL_SEQ;
        if (exception)                                 sel = SEL_EXC;
        else if (!enable)                              sel = SEL_HOLD;
        else if (jr && (jr_target[ALIGN_BITS-1:0] != '0)) sel = SEL_FAULT;
        else if (jr)                                   sel = SEL_JR;
        else if (jump)                                 sel = SEL_JUMP;
        else if (branch_taken)                         sel = SEL_BRANCH;
    end

    always_comb begin
        pc_d     = pc_next_seq;
        hold     = 1'b0;
        epc_load = 1'b0;
        mis_d    = 1'b0;
        case (sel)
            SEL_EXC: begin
                pc_d     = EXC_VECTOR;
                epc_load = 1'b1;
            end
            SEL_HOLD: begin
                pc_d = pc;
                hold = 1'b1;
            end
            SEL_FAULT: begin
                pc_d     = EXC_VECTOR;
                epc_load = 1'b1;
                mis_d    = 1'b1;
            end
            SEL_JR:     pc_d = jr_target;
            SEL_JUMP:   pc_d = j_target;
            SEL_BRANCH: pc_d = br_target;
            default:    pc_d = pc_next_seq;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit: owns pc, epc and the misaligned-jr pulse; next-PC
// selection comes from pc_next_sel.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned       WIDTH        = DEF_WIDTH,
    parameter int unsigned       INC          = DEF_INC,
    parameter int unsigned       ALIGN_BITS   = DEF_ALIGN_BITS,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
    parameter logic [WIDTH-1:0]  EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          branch_taken,
    input  logic [WIDTH-1:0]              branch_offset,
    input  logic                          jump,
    input  logic [WIDTH-4-ALIGN_BITS-1:0] jump_index,
    input  logic                          jr,
    input  logic [WIDTH-1:0]              jr_target,
    input  logic                          exception,
    output logic [WIDTH-1:0]              pc,
    output logic [WIDTH-1:0]              pc_next_seq,
    output logic [WIDTH-1:0]              epc,
    output logic                          misaligned
);

    logic [WIDTH-1:0] pc_d;
    logic             hold;
    logic             epc_load;
    logic             mis_d;

    pc_next_sel #(
        .WIDTH      (WIDTH),
        .INC        (INC),
        .ALIGN_BITS (ALIGN_BITS),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_sel (
        .pc            (pc),
        .enable        (enable),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .jr            (jr),
        .jr_target     (jr_target),
        .exception     (exception),
        .pc_next_seq   (pc_next_seq),
        .pc_d          (pc_d),
        .hold          (hold),
        .epc_load      (epc_load),
        .mis_d         (mis_d)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc         <= RESET_VECTOR;
            epc        <= '0;
            misaligned <= 1'b0;
        end else begin
            misaligned <= mis_d;
            if (!hold)    pc  <= pc_d;
            if (epc_load) epc <= pc;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

    localparam logic [31:0] EXC = 32'h8000_0180;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic        exception;
    logic [31:0] pc;
    logic [31:0] pc_next_seq;
    logic [31:0] epc;
    logic        misaligned;

    int nvec = 0;
    int nmis = 0;

    always #5 clock = ~clock;

    pc_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .jr            (jr),
        .jr_target     (jr_target),
        .exception     (exception),
        .pc            (pc),
        .pc_next_seq   (pc_next_seq),
        .epc           (epc),
        .misaligned    (misaligned)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Uses an aligned jr to place pc at a known value.
    task automatic load_pc(input logic [31:0] v);
        jr        = 1'b1;
        jr_target = v;
        step();
        jr        = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; branch_taken = 1'b0; branch_offset = '0;
        jump = 1'b0; jump_index = '0; jr = 1'b0; jr_target = '0; exception = 1'b0;

        #3 reset = 1'b0;
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_mis", {31'b0, misaligned}, 32'h0);
        #8;
        reset = 1'b1; enable = 1'b1;
        chk("rel_pc0", pc, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("seq_pc", pc, 32'(4 * i));
        end

        load_pc(32'h40);
        chk("jr_pc", pc, 32'h40);
        enable = 1'b0;
        step(); chk("stall1", pc, 32'h40);
        step(); chk("stall2", pc, 32'h40);
        chk("stall_epc", epc, 32'h0);
        enable = 1'b1;
        step(); chk("unstall", pc, 32'h44);

        load_pc(32'h100);
        branch_taken = 1'b1; branch_offset = 32'hFFFF_FFFE;
        step(); chk("br_neg", pc, 32'h0000_00FC);
        branch_taken = 1'b0;
        load_pc(32'h100);
        branch_taken = 1'b1; branch_offset = 32'h3;
        step(); chk("br_pos", pc, 32'h0000_0110);
        branch_taken = 1'b0;

        load_pc(32'h0040_0000);
        jump = 1'b1; branch_taken = 1'b1; jump_index = 26'h10;
        step(); chk("jmp_over_br", pc, 32'h0000_0040);
        load_pc(32'h0040_0000);
        jr = 1'b1; jr_target = 32'h2000; jump = 1'b1; branch_taken = 1'b1;
        step(); chk("jr_over_jmp", pc, 32'h0000_2000);
        jr = 1'b0; jump = 1'b0; branch_taken = 1'b0;

        load_pc(32'h80);
        chk("jr_ok_mis", {31'b0, misaligned}, 32'h0);
        jr = 1'b1; jr_target = 32'h2002;
        step();
        chk("mis_pc", pc, EXC);
        chk("mis_epc", epc, 32'h80);
        chk("mis_pulse", {31'b0, misaligned}, 32'h1);
        jr = 1'b0;
        step();
        chk("mis_clr", {31'b0, misaligned}, 32'h0);
        chk("mis_next", pc, 32'h8000_0184);

        load_pc(32'hFFFF_FFFC);
        chk("wrap_seq", pc_next_seq, 32'h0);
        step(); chk("wrap_pc", pc, 32'h0);
        chk("seq_comb", pc_next_seq, 32'h4);

        load_pc(32'h20);
        enable = 1'b0; exception = 1'b1;
        step();
        chk("exc_pc", pc, EXC);
        chk("exc_epc", epc, 32'h20);
        exception = 1'b0;
        step(); chk("exc_hold", pc, EXC);
        enable = 1'b1;

        load_pc(32'h80);
        jr = 1'b1; jr_target = 32'h2001;
        step();
        chk("mis2_pulse", {31'b0, misaligned}, 32'h1);
        jump = 1'b1; exception = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_epc", epc, 32'h0);
        chk("mid_rst_mis", {31'b0, misaligned}, 32'h0);
        step();
        chk("rst_held", pc, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
